// File: rtl/wb_arbiter2_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM state and counter widths.
package wb_arbiter2_pkg;

    localparam int unsigned OUTST_W = 4;
    localparam int unsigned BURST_W = 8;

    typedef enum logic [1:0] {
        GRANT0 = 2'd0,
        DRAIN0 = 2'd1,
        GRANT1 = 2'd2,
        DRAIN1 = 2'd3
    } arb_state_t;

    // The upper state bit is the owning master.
    function automatic logic state_gnt(arb_state_t st);
        return st[1];
    endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bundle (stall/ack); dat_m flows master->slave, dat_s slave->master.
interface if_wb;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        stall;
    logic        ack;

    modport master (output cyc, stb, we, adr, dat_m, input dat_s, stall, ack);
    modport slave (input cyc, stb, we, adr, dat_m, output dat_s, stall, ack);

endinterface

// File: rtl/wb_outst_counter.sv
// Count of accepted-but-unacked Wishbone transactions; acks arriving at zero are stray.
module wb_outst_counter
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
    input  logic               ack,
    output logic [OUTST_W-1:0] count,
    output logic [OUTST_W-1:0] count_next,
    output logic               full,
    output logic               ack_valid
);

    localparam logic [OUTST_W-1:0] MaxCnt = OUTST_W'(MAX_OUTST);

    logic [OUTST_W-1:0] count_q, count_d;

    assign ack_valid  = ack && (count_q != '0);
    assign full       = (count_q >= MaxCnt);
    assign count      = count_q;
    assign count_next = count_d;

    always_comb begin
        count_d = count_q;
        if (accept && !ack_valid) begin
            count_d = count_q + 1'b1;
        end else if (!accept && ack_valid) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter with per-strobe burst limits and a
// drain phase before every hand-over.
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic clk,
    input  logic reset,
    if_wb.slave  m0,
    if_wb.slave  m1,
    if_wb.master s,
    output logic gnt
);

    localparam logic [BURST_W:0] BurstLim = (BURST_W + 1)'(MAX_BURST);

    arb_state_t         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W:0]   burst_sum;
    logic [OUTST_W-1:0] outst, outst_next;
    logic               owner_cyc, owner_stb, other_cyc, draining;
    logic               accept, full, ack_valid;

    assign gnt       = state_gnt(state_q);
    assign draining  = (state_q == DRAIN0) || (state_q == DRAIN1);
    assign owner_cyc = gnt ? m1.cyc : m0.cyc;
    assign owner_stb = gnt ? m1.stb : m0.stb;
    assign other_cyc = gnt ? m0.cyc : m1.cyc;
    assign accept    = s.stb && !s.stall;
    assign burst_sum = {1'b0, burst_q} + {{BURST_W{1'b0}}, accept};

    wb_outst_counter #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .ack        (s.ack),
        .count      (outst),
        .count_next (outst_next),
        .full       (full),
        .ack_valid  (ack_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GRANT0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GRANT0, GRANT1: begin
                if (other_cyc) begin
                    // Idle owner with nothing in flight hands over without draining.
                    if (!owner_cyc && (outst == '0)) begin
                        state_d = gnt ? GRANT0 : GRANT1;
                    end else if (!owner_cyc || (burst_sum >= BurstLim)) begin
                        state_d = gnt ? DRAIN1 : DRAIN0;
                    end
                end
            end
            DRAIN0, DRAIN1: begin
                if (!other_cyc) begin
                    state_d = gnt ? GRANT1 : GRANT0;
                end else if (outst_next == '0) begin
                    state_d = gnt ? GRANT0 : GRANT1;
                end
            end
        endcase
    end

    always_comb begin
        burst_d = burst_q;
        if ((state_gnt(state_d) != gnt) || !other_cyc) begin
            burst_d = '0;
        end else if (accept) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = gnt ? m1.we : m0.we;
        s.adr    = gnt ? m1.adr : m0.adr;
        s.dat_m  = gnt ? m1.dat_m : m0.dat_m;
        m0.dat_s = s.dat_s;
        m1.dat_s = s.dat_s;
        m0.stall = 1'b1;
        m1.stall = 1'b1;
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        if (!reset) begin
            s.cyc = owner_cyc || (draining && (outst != '0));
            s.stb = !draining && owner_cyc && owner_stb && !full;
            if (gnt) begin
                m1.stall = draining || full || s.stall;
                m1.ack   = ack_valid;
            end else begin
                m0.stall = draining || full || s.stall;
                m0.ack   = ack_valid;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: fixed vector table, hand-written reset/drain sequence and random
// traffic, all checked against a cycle-level reference model of the arbitration rules.
module tb_wb_arbiter2;

    localparam int P_BURST = 4;
    localparam int P_OUTST = 3;

    logic clk;
    logic rst;
    logic gnt;

    if_wb m0_if ();
    if_wb m1_if ();
    if_wb s_if ();

    wb_arbiter2 #(
        .MAX_BURST (P_BURST),
        .MAX_OUTST (P_OUTST)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .gnt   (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner, drain flag, in-flight count, strobes granted in this burst.
    bit m_owner, m_drain, nx_owner, nx_drain;
    int m_outst, m_burst, nx_outst, nx_burst;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit oc, os, xc, full, e_stb, e_cyc, e_ack, acc;
        int n_out;
        if (rst) begin
            check("rst_gnt", gnt, 0);
            check("rst_s_cyc", s_if.cyc, 0);
            check("rst_s_stb", s_if.stb, 0);
            check("rst_m0_stall", m0_if.stall, 1);
            check("rst_m1_stall", m1_if.stall, 1);
            check("rst_m0_ack", m0_if.ack, 0);
            check("rst_m1_ack", m1_if.ack, 0);
            nx_owner = 0; nx_drain = 0; nx_outst = 0; nx_burst = 0;
            return;
        end
        oc    = m_owner ? m1_if.cyc : m0_if.cyc;
        os    = m_owner ? m1_if.stb : m0_if.stb;
        xc    = m_owner ? m0_if.cyc : m1_if.cyc;
        full  = m_outst >= P_OUTST;
        e_stb = !m_drain && oc && os && !full;
        e_cyc = oc || (m_drain && m_outst > 0);
        e_ack = s_if.ack && m_outst > 0;
        acc   = e_stb && !s_if.stall;
        check("gnt", gnt, 16'(m_owner));
        check("s_cyc", s_if.cyc, 16'(e_cyc));
        check("s_stb", s_if.stb, 16'(e_stb));
        check("m0_ack", m0_if.ack, 16'(!m_owner && e_ack));
        check("m1_ack", m1_if.ack, 16'(m_owner && e_ack));
        check("m0_stall", m0_if.stall, 16'(m_owner || m_drain || full || s_if.stall));
        check("m1_stall", m1_if.stall, 16'(!m_owner || m_drain || full || s_if.stall));
        check("m0_dat_s", m0_if.dat_s, s_if.dat_s);
        check("m1_dat_s", m1_if.dat_s, s_if.dat_s);
        if (e_cyc) begin
            check("s_adr", s_if.adr, m_owner ? m1_if.adr : m0_if.adr);
            check("s_dat_m", s_if.dat_m, m_owner ? m1_if.dat_m : m0_if.dat_m);
            check("s_we", s_if.we, 16'(m_owner ? m1_if.we : m0_if.we));
        end
        n_out    = m_outst + int'(acc) - int'(e_ack);
        nx_owner = m_owner; nx_drain = m_drain; nx_outst = n_out; nx_burst = m_burst;
        if (!m_drain) begin
            nx_burst = xc ? m_burst + int'(acc) : 0;
            if (xc && !oc && m_outst == 0) begin
                nx_owner = !m_owner;
                nx_burst = 0;
            end else if (xc && (!oc || m_burst + int'(acc) >= P_BURST)) begin
                nx_drain = 1;
            end
        end else if (!xc) begin
            nx_drain = 0;
            nx_burst = 0;
        end else if (n_out == 0) begin
            nx_owner = !m_owner;
            nx_drain = 0;
            nx_burst = 0;
        end
    endtask

    task automatic commit();
        @(posedge clk);
        m_owner = nx_owner; m_drain = nx_drain; m_outst = nx_outst; m_burst = nx_burst;
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        commit();
    endtask

    task automatic drive(input bit c0, s0, c1, s1, st, ak);
        m0_if.cyc = c0; m0_if.stb = s0;
        m1_if.cyc = c1; m1_if.stb = s1;
        s_if.stall = st; s_if.ack = ak;
    endtask

    // Row layout: {m0 cyc, m0 stb, m1 cyc, m1 stb, s stall, s ack} _ {gnt, s cyc, s stb,
    // m0 ack, m1 ack}; each row is one clock.
    typedef struct packed {
        logic c0, s0, c1, s1, st, ak;
        logic g, sc, ss, a0, a1;
    } vec_t;

    vec_t vecs [18];

    initial begin
        vecs[0]  = 11'b000001_00000;  // stray ack at outstanding 0
        vecs[1]  = 11'b110000_01100;
        vecs[2]  = 11'b110011_01110;
        vecs[3]  = 11'b111100_01100;  // m1 requests: burst 1
        vecs[4]  = 11'b111100_01100;
        vecs[5]  = 11'b111100_01100;  // outstanding reaches 3
        vecs[6]  = 11'b111100_01000;  // saturated
        vecs[7]  = 11'b111101_01010;
        vecs[8]  = 11'b111100_01100;  // 4th burst accept -> DRAIN0
        vecs[9]  = 11'b111101_01010;
        vecs[10] = 11'b111101_01010;
        vecs[11] = 11'b111101_01010;  // final ack -> GRANT1
        vecs[12] = 11'b111100_11100;
        vecs[13] = 11'b111101_11101;
        vecs[14] = 11'b111001_11001;
        vecs[15] = 11'b110000_10000;  // m1 releases, nothing in flight
        vecs[16] = 11'b110000_01100;  // m0 fetch at 0x0000
        vecs[17] = 11'b100001_01010;

        m_owner = 0; m_drain = 0; m_outst = 0; m_burst = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        m0_if.we = 1'b0; m0_if.adr = '0; m0_if.dat_m = '0;
        m1_if.we = 1'b1; m1_if.adr = 16'h8000; m1_if.dat_m = 16'hBEEF;
        s_if.dat_s = 16'h1234;
        repeat (2) cycle();
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1, vecs[i].st, vecs[i].ak);
            m0_if.adr  = (i == 16) ? 16'h0000 : 16'h0010 + 16'(i);
            s_if.dat_s = 16'hA000 + 16'(i);
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), gnt, 16'(vecs[i].g));
            check($sformatf("vec%0d_s_cyc", i), s_if.cyc, 16'(vecs[i].sc));
            check($sformatf("vec%0d_s_stb", i), s_if.stb, 16'(vecs[i].ss));
            check($sformatf("vec%0d_m0_ack", i), m0_if.ack, 16'(vecs[i].a0));
            check($sformatf("vec%0d_m1_ack", i), m1_if.ack, 16'(vecs[i].a1));
            if (i == 12) begin
                check("m1_wr_adr", s_if.adr, 16'h8000);
                check("m1_wr_dat", s_if.dat_m, 16'hBEEF);
                check("m1_wr_we", s_if.we, 16'h1);
            end
            if (i == 16) check("release_adr", s_if.adr, 16'h0000);
            model_eval();
            commit();
        end

        // Enter DRAIN1 with one transaction in flight, then reset asynchronously.
        drive(0, 0, 1, 1, 0, 0);
        cycle();
        cycle();
        drive(1, 1, 0, 0, 0, 0);
        cycle();
        check("drain1_gnt", gnt, 16'h1);
        check("drain1_s_cyc", s_if.cyc, 16'h1);
        check("drain1_s_stb", s_if.stb, 16'h0);
        rst = 1'b1;
        s_if.ack = 1'b1;
        #1;
        check("async_rst_gnt", gnt, 16'h0);
        check("async_rst_s_cyc", s_if.cyc, 16'h0);
        check("async_rst_m1_ack", m1_if.ack, 16'h0);
        cycle();
        rst = 1'b0;
        #1;
        check("post_rst_stray_m0_ack", m0_if.ack, 16'h0);
        check("post_rst_stray_m1_ack", m1_if.ack, 16'h0);
        cycle();

        for (int i = 0; i < 3000; i++) begin
            m0_if.cyc   = $urandom_range(0, 9) != 0;
            m0_if.stb   = $urandom_range(0, 3) != 0;
            m1_if.cyc   = ($urandom_range(0, 9) == 0) ? !m1_if.cyc : m1_if.cyc;
            m1_if.stb   = $urandom_range(0, 1) != 0;
            m0_if.we    = $urandom_range(0, 1) != 0;
            m1_if.we    = $urandom_range(0, 1) != 0;
            m0_if.adr   = 16'($urandom);
            m1_if.adr   = 16'($urandom);
            m0_if.dat_m = 16'($urandom);
            m1_if.dat_m = 16'($urandom);
            s_if.dat_s  = 16'($urandom);
            s_if.stall  = $urandom_range(0, 2) == 0;
            s_if.ack    = $urandom_range(0, 2) == 0;
            rst         = $urandom_range(0, 499) == 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
